// File: rtl/maquina_pkg.sv
// rtl/maquina_pkg.sv - shared state codes and width helper for the multi-cup coffee machine
//   Purpose: 4-bit state encodings consumed by the FSM and the display/LED decoder,
//            plus a width helper used to size the level, cup and timer registers.
//   Ports:   none (package).
package maquina_pkg;

  localparam logic [3:0] ST_IDLE     = 4'd1;
  localparam logic [3:0] ST_LIGAR    = 4'd2;
  localparam logic [3:0] ST_VERIF    = 4'd3;
  localparam logic [3:0] ST_ENCHER   = 4'd4;
  localparam logic [3:0] ST_MOER     = 4'd5;
  localparam logic [3:0] ST_COLOCAR  = 4'd6;
  localparam logic [3:0] ST_AGITADOR = 4'd7;
  localparam logic [3:0] ST_TAMPEAR  = 4'd8;
  localparam logic [3:0] ST_EXTRACAO = 4'd9;

  // Bits needed to hold every value in 0..max_val (at least 1).
  function automatic int width_for(input int max_val);
    int w;
    w = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) <= max_val) w = i + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/maquina_cafe_multi_stage_timer.sv
// rtl/maquina_cafe_multi_stage_timer.sv - loadable down-counter for per-stage dwell time
//   Purpose: holds the remaining dwell cycles of the current brewing stage.
//   Ports:   clk, rst (async, active-high), load, load_value [W-1:0] in;
//            expired out (high while the count is zero).
module stage_timer #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_value,
  output logic         expired
);

  logic [W-1:0] count_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else if (load) begin
      count_q <= load_value;
    end else if (count_q != '0) begin
      count_q <= count_q - W'(1);
    end
  end

  assign expired = (count_q == '0);

endmodule

// File: rtl/maquina_cafe_multi.sv
// rtl/maquina_cafe_multi.sv - multi-cup coffee machine FSM with water reservoir and abort
//   Purpose: brews 1..MAX_CUPS cups per request, refilling the reservoir as needed.
//   Ports:   clk, rst (async, active-high), start, cups [CW-1:0], abort in;
//            state [3:0], busy, cups_left [CW-1:0], water_level [LW-1:0],
//            done, aborted out.
module maquina_cafe_multi
  import maquina_pkg::*;
#(
  parameter  int WATER_CAP      = 4,
  parameter  int WATER_PER_CUP  = 1,
  parameter  int FILL_RATE      = 4,
  parameter  int GRIND_CYCLES   = 1,
  parameter  int EXTRACT_CYCLES = 1,
  parameter  int MAX_CUPS       = 4,
  localparam int CW             = width_for(MAX_CUPS),
  localparam int LW             = width_for(WATER_CAP)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [CW-1:0] cups,
  input  logic          abort,
  output logic [3:0]    state,
  output logic          busy,
  output logic [CW-1:0] cups_left,
  output logic [LW-1:0] water_level,
  output logic          done,
  output logic          aborted
);

  localparam int MAX_DWELL = (GRIND_CYCLES > EXTRACT_CYCLES) ? GRIND_CYCLES : EXTRACT_CYCLES;
  localparam int TW        = width_for(MAX_DWELL);
  // A fill step larger than the tank behaves like a full refill; clamping keeps the adder narrow.
  localparam int FILL_EFF  = (FILL_RATE > WATER_CAP) ? WATER_CAP : FILL_RATE;

  localparam logic [LW-1:0] CAP     = LW'(WATER_CAP);
  localparam logic [LW-1:0] PER_CUP = LW'(WATER_PER_CUP);
  localparam logic [LW:0]   FILL    = (LW + 1)'(FILL_EFF);
  localparam logic [CW-1:0] MAX_C   = CW'(MAX_CUPS);

  logic [3:0]    state_q, state_d;
  logic [CW-1:0] cups_left_q;
  logic [LW-1:0] level_q;
  logic          done_q, aborted_q;
  logic          expired;
  logic          timer_load;
  logic [TW-1:0] timer_value;
  logic [LW:0]   fill_sum;
  logic [LW-1:0] level_fill;
  logic [CW-1:0] cups_clamped;
  logic          abort_hit;

  function automatic logic [TW-1:0] dwell_of(input logic [3:0] st);
    case (st)
      ST_MOER:     return TW'(GRIND_CYCLES - 1);
      ST_EXTRACAO: return TW'(EXTRACT_CYCLES - 1);
      default:     return '0;
    endcase
  endfunction

  assign fill_sum     = {1'b0, level_q} + FILL;
  assign level_fill   = (fill_sum >= {1'b0, CAP}) ? CAP : fill_sum[LW-1:0];
  assign cups_clamped = (cups > MAX_C) ? MAX_C : cups;
  assign abort_hit    = abort && (state_q != ST_IDLE);

  // Every state change reloads the dwell timer for the stage being entered.
  assign timer_load  = (state_d != state_q);
  assign timer_value = dwell_of(state_d);

  stage_timer #(.W(TW)) u_timer (
    .clk        (clk),
    .rst        (rst),
    .load       (timer_load),
    .load_value (timer_value),
    .expired    (expired)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:      if (start && (cups != '0)) state_d = ST_LIGAR;
      ST_LIGAR:     state_d = ST_VERIF;
      ST_VERIF:     state_d = (level_q >= PER_CUP) ? ST_MOER : ST_ENCHER;
      ST_ENCHER:    if (level_fill == CAP) state_d = ST_VERIF;
      ST_MOER:      if (expired) state_d = ST_COLOCAR;
      ST_COLOCAR:   state_d = ST_AGITADOR;
      ST_AGITADOR:  state_d = ST_TAMPEAR;
      ST_TAMPEAR:   state_d = ST_EXTRACAO;
      // Later cups skip LIGAR: the machine is already on.
      ST_EXTRACAO:  if (expired) state_d = (cups_left_q > CW'(1)) ? ST_VERIF : ST_IDLE;
      default:      state_d = ST_IDLE;
    endcase
    if (abort_hit) state_d = ST_IDLE;
  end

  // Datapath registers: reservoir level, cup counter and handshake pulses
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      level_q     <= '0;
      cups_left_q <= '0;
      done_q      <= 1'b0;
      aborted_q   <= 1'b0;
    end else begin
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
      if (abort_hit) begin
        // Level is left as is: the aborted cup is neither consumed nor refunded.
        cups_left_q <= '0;
        aborted_q   <= 1'b1;
      end else begin
        case (state_q)
          ST_IDLE:     if (start && (cups != '0)) cups_left_q <= cups_clamped;
          ST_ENCHER:   level_q <= level_fill;
          ST_EXTRACAO: begin
            if (expired) begin
              level_q <= level_q - PER_CUP;
              if (cups_left_q > CW'(1)) begin
                cups_left_q <= cups_left_q - CW'(1);
              end else begin
                cups_left_q <= '0;
                done_q      <= 1'b1;
              end
            end
          end
          ST_LIGAR, ST_VERIF, ST_MOER, ST_COLOCAR, ST_AGITADOR, ST_TAMPEAR: ;
          default:     cups_left_q <= '0;
        endcase
      end
    end
  end

  // Output decode
  always_comb begin
    busy = (state_q != ST_IDLE);
  end

  assign state       = state_q;
  assign cups_left   = cups_left_q;
  assign water_level = level_q;
  assign done        = done_q;
  assign aborted     = aborted_q;

endmodule

// File: tb/tb_maquina_cafe_multi.sv
// tb/tb_maquina_cafe_multi.sv - directed self-checking bench for maquina_cafe_multi
module tb_maquina_cafe_multi;

  logic       clk = 1'b0;
  logic       rst;
  logic       start, abort;
  logic [2:0] cups;
  logic [3:0] state;
  logic       busy, done, aborted;
  logic [2:0] cups_left, water_level;

  logic       start4, abort4;
  logic [2:0] cups4;
  logic [3:0] state4;
  logic       busy4, done4, aborted4;
  logic [2:0] cups_left4, water_level4;

  int vectors = 0;
  int fails   = 0;
  int dcount;

  always #5 clk = ~clk;

  maquina_cafe_multi dut (
    .clk(clk), .rst(rst), .start(start), .cups(cups), .abort(abort),
    .state(state), .busy(busy), .cups_left(cups_left), .water_level(water_level),
    .done(done), .aborted(aborted)
  );

  maquina_cafe_multi #(
    .WATER_CAP(4), .WATER_PER_CUP(1), .FILL_RATE(1),
    .GRIND_CYCLES(3), .EXTRACT_CYCLES(2), .MAX_CUPS(4)
  ) dut4 (
    .clk(clk), .rst(rst), .start(start4), .cups(cups4), .abort(abort4),
    .state(state4), .busy(busy4), .cups_left(cups_left4), .water_level(water_level4),
    .done(done4), .aborted(aborted4)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  int seq1 [10] = '{2, 3, 4, 3, 5, 6, 7, 8, 9, 1};
  int seq2 [8]  = '{2, 3, 5, 6, 7, 8, 9, 1};
  int seq3 [22] = '{2, 3, 4, 3, 5, 6, 7, 8, 9,
                    3, 5, 6, 7, 8, 9,
                    3, 5, 6, 7, 8, 9,
                    1};
  int cl3  [22] = '{3, 3, 3, 3, 3, 3, 3, 3, 3,
                    2, 2, 2, 2, 2, 2,
                    1, 1, 1, 1, 1, 1,
                    0};
  int seq4 [16] = '{2, 3, 4, 4, 4, 4, 3, 5, 5, 5, 6, 7, 8, 9, 9, 1};

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; cups = '0;
    start4 = 1'b0; abort4 = 1'b0; cups4 = '0;
    #2;
    chk("rst_state", state, 1);
    chk("rst_busy", busy, 0);
    chk("rst_level", water_level, 0);
    chk("rst_cups_left", cups_left, 0);
    chk("rst_done", done, 0);
    chk("rst_aborted", aborted, 0);
    step();
    rst = 1'b0;

    // Test 1: first brew, reservoir empty
    start = 1'b1; cups = 3'd1;
    step();
    start = 1'b0;
    dcount = 0;
    for (int i = 0; i < 10; i++) begin
      chk("t1_state", state, seq1[i]);
      if (done) dcount++;
      if (i < 9) step();
    end
    chk("t1_done_last", done, 1);
    chk("t1_done_count", dcount, 1);
    chk("t1_level", water_level, 3);
    step();
    chk("t1_done_clear", done, 0);

    // Test 2: second brew, no refill
    start = 1'b1; cups = 3'd1;
    step();
    start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk("t2_state", state, seq2[i]);
      if (i < 7) step();
    end
    chk("t2_level", water_level, 2);

    // Test 3: three cups from reset
    rst = 1'b1;
    step();
    rst = 1'b0;
    start = 1'b1; cups = 3'd3;
    step();
    start = 1'b0;
    dcount = 0;
    for (int i = 0; i < 22; i++) begin
      chk("t3_state", state, seq3[i]);
      chk("t3_cups_left", cups_left, cl3[i]);
      if (done) dcount++;
      if (i < 21) step();
    end
    chk("t3_done_count", dcount, 1);
    chk("t3_level", water_level, 1);

    // Test 4: stretched dwell times and slow fill
    start4 = 1'b1; cups4 = 3'd1;
    step();
    start4 = 1'b0;
    for (int i = 0; i < 16; i++) begin
      chk("t4_state", state4, seq4[i]);
      if (i < 15) step();
    end
    chk("t4_done", done4, 1);
    chk("t4_level", water_level4, 3);

    // Test 5: abort during grinding
    rst = 1'b1;
    step();
    rst = 1'b0;
    start = 1'b1; cups = 3'd1;
    step();
    start = 1'b0;
    for (int i = 0; i < 4; i++) step();
    chk("t5_pre_state", state, 5);
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("t5_state", state, 1);
    chk("t5_aborted", aborted, 1);
    chk("t5_done", done, 0);
    chk("t5_cups_left", cups_left, 0);
    chk("t5_level", water_level, 4);
    chk("t5_busy", busy, 0);
    step();
    chk("t5_aborted_clear", aborted, 0);

    // Test 6: boundaries
    start = 1'b1; cups = 3'd0;
    step();
    start = 1'b0;
    chk("t6_zero_state", state, 1);
    chk("t6_zero_busy", busy, 0);
    chk("t6_zero_cups_left", cups_left, 0);

    start = 1'b1; cups = 3'd7;
    step();
    start = 1'b0;
    chk("t6_clamp_cups_left", cups_left, 4);
    chk("t6_clamp_state", state, 2);
    for (int i = 0; i < 3; i++) step();
    chk("t6_pre_state", state, 6);
    start = 1'b1; cups = 3'd1;
    step();
    start = 1'b0;
    chk("t6_busy_start_state", state, 7);
    chk("t6_busy_start_cups_left", cups_left, 4);

    rst = 1'b1;
    #2;
    chk("t6_async_state", state, 1);
    chk("t6_async_level", water_level, 0);
    chk("t6_async_cups_left", cups_left, 0);
    step();
    rst = 1'b0;

    // start and abort together in IDLE: start wins
    start = 1'b1; abort = 1'b1; cups = 3'd2;
    step();
    start = 1'b0; abort = 1'b0;
    chk("t6_sa_state", state, 2);
    chk("t6_sa_aborted", aborted, 0);
    chk("t6_sa_cups_left", cups_left, 2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
